// File: rtl/riscv_pipe_pkg.sv
// Shared decode-control types for the RV32 pipeline: control struct, ALU/WB selectors,
// the bubble constant and operand-usage helpers.
package riscv_pipe_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  typedef struct packed {
    logic    is_LUI;
    logic    is_AUIPC;
    logic    is_B_type;
    logic    is_JAL;
    logic    is_R_type;
    logic    reg_wr;
    logic    mem_rd;
    logic    mem_wr;
    alu_op_t alu_op;
    wb_sel_t wb_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    is_LUI:    1'b0,
    is_AUIPC:  1'b0,
    is_B_type: 1'b0,
    is_JAL:    1'b0,
    is_R_type: 1'b0,
    reg_wr:    1'b0,
    mem_rd:    1'b0,
    mem_wr:    1'b0,
    alu_op:    ALU_ADD,
    wb_sel:    WB_ALU
  };

  // U-type and JAL carry no rs1 field; only R, S (stores) and B read rs2.
  function automatic logic uses_rs1(input ctrl_t c);
    return !(c.is_LUI || c.is_AUIPC || c.is_JAL);
  endfunction

  function automatic logic uses_rs2(input ctrl_t c);
    return c.is_R_type || c.mem_wr || c.is_B_type;
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is read by
// the instruction in ID.
module load_use_detect #(
  parameter int RIDX_W = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_rd,
  input  logic [RIDX_W-1:0] ex_rd,
  input  logic              id_valid,
  input  logic [RIDX_W-1:0] id_rs1,
  input  logic [RIDX_W-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  output logic              load_use
);

  logic hit_rs1;
  logic hit_rs2;

  assign hit_rs1  = (ex_rd == id_rs1) && id_uses_rs1;
  assign hit_rs2  = (ex_rd == id_rs2) && id_uses_rs2;
  assign load_use = ex_valid && ex_mem_rd && (ex_rd != '0) && id_valid && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with load-use stall, flush bubbles and, when
// ID_EX_RF_BYPASS_EN is defined, a WB->ID write-through operand bypass.
module id_ex_stage_reg
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int RIDX_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rdata1,
  input  logic [XLEN-1:0]   id_rdata2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [RIDX_W-1:0] id_rs1,
  input  logic [RIDX_W-1:0] id_rs2,
  input  logic [RIDX_W-1:0] id_rd,
  input  ctrl_t             id_ctrl,
  input  logic              ex_flush,
`ifdef ID_EX_RF_BYPASS_EN
  input  logic              wb_we,
  input  logic [RIDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
`endif
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rdata1,
  output logic [XLEN-1:0]   ex_rdata2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [RIDX_W-1:0] ex_rs1,
  output logic [RIDX_W-1:0] ex_rs2,
  output logic [RIDX_W-1:0] ex_rd,
  output ctrl_t             ex_ctrl,
  output logic              stall_fd
);

  logic              load_use;
  logic [XLEN-1:0]   opnd1_p0;
  logic [XLEN-1:0]   opnd2_p0;

  logic              vld_p1;
  logic [XLEN-1:0]   pc_p1;
  logic [XLEN-1:0]   rdata1_p1;
  logic [XLEN-1:0]   rdata2_p1;
  logic [XLEN-1:0]   imm_p1;
  logic [RIDX_W-1:0] rs1_p1;
  logic [RIDX_W-1:0] rs2_p1;
  logic [RIDX_W-1:0] rd_p1;
  ctrl_t             ctrl_p1;

  load_use_detect #(.RIDX_W(RIDX_W)) u_load_use_detect (
    .ex_valid    (vld_p1),
    .ex_mem_rd   (ctrl_p1.mem_rd),
    .ex_rd       (rd_p1),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (uses_rs1(id_ctrl)),
    .id_uses_rs2 (uses_rs2(id_ctrl)),
    .load_use    (load_use)
  );

  assign stall_fd = load_use && !ex_flush;

  // ---- ID stage (p0): operand select ----
`ifdef ID_EX_RF_BYPASS_EN
  always_comb begin
    opnd1_p0 = id_rdata1;
    opnd2_p0 = id_rdata2;
    if (wb_we && (wb_rd != '0) && (wb_rd == id_rs1)) opnd1_p0 = wb_data;
    if (wb_we && (wb_rd != '0) && (wb_rd == id_rs2)) opnd2_p0 = wb_data;
  end
`else
  assign opnd1_p0 = id_rdata1;
  assign opnd2_p0 = id_rdata2;
`endif

  // ---- ID/EX boundary (p1): flush beats stall; a bubble keeps stale data but no side effects ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      ctrl_p1   <= CTRL_NOP;
      pc_p1     <= '0;
      rdata1_p1 <= '0;
      rdata2_p1 <= '0;
      imm_p1    <= '0;
      rs1_p1    <= '0;
      rs2_p1    <= '0;
      rd_p1     <= '0;
    end else if (ex_flush || load_use) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= CTRL_NOP;
    end else begin
      vld_p1    <= id_valid;
      ctrl_p1   <= id_valid ? id_ctrl : CTRL_NOP;
      pc_p1     <= id_pc;
      rdata1_p1 <= opnd1_p0;
      rdata2_p1 <= opnd2_p0;
      imm_p1    <= id_imm;
      rs1_p1    <= id_rs1;
      rs2_p1    <= id_rs2;
      rd_p1     <= id_rd;
    end
  end

  assign ex_valid  = vld_p1;
  assign ex_pc     = pc_p1;
  assign ex_rdata1 = rdata1_p1;
  assign ex_rdata2 = rdata2_p1;
  assign ex_imm    = imm_p1;
  assign ex_rs1    = rs1_p1;
  assign ex_rs2    = rs2_p1;
  assign ex_rd     = rd_p1;
  assign ex_ctrl   = ctrl_p1;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg; bypass steps run only when ID_EX_RF_BYPASS_EN is defined.
module tb_id_ex_stage_reg;
  import riscv_pipe_pkg::*;

  localparam int XLEN   = 32;
  localparam int RIDX_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [XLEN-1:0]   id_pc, id_rdata1, id_rdata2, id_imm;
  logic [RIDX_W-1:0] id_rs1, id_rs2, id_rd;
  ctrl_t             id_ctrl;
  logic              ex_flush;
`ifdef ID_EX_RF_BYPASS_EN
  logic              wb_we;
  logic [RIDX_W-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
`endif
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc, ex_rdata1, ex_rdata2, ex_imm;
  logic [RIDX_W-1:0] ex_rs1, ex_rs2, ex_rd;
  ctrl_t             ex_ctrl;
  logic              stall_fd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.XLEN(XLEN), .RIDX_W(RIDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_valid  (id_valid),
    .id_pc     (id_pc),
    .id_rdata1 (id_rdata1),
    .id_rdata2 (id_rdata2),
    .id_imm    (id_imm),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .id_rd     (id_rd),
    .id_ctrl   (id_ctrl),
    .ex_flush  (ex_flush),
`ifdef ID_EX_RF_BYPASS_EN
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
`endif
    .ex_valid  (ex_valid),
    .ex_pc     (ex_pc),
    .ex_rdata1 (ex_rdata1),
    .ex_rdata2 (ex_rdata2),
    .ex_imm    (ex_imm),
    .ex_rs1    (ex_rs1),
    .ex_rs2    (ex_rs2),
    .ex_rd     (ex_rd),
    .ex_ctrl   (ex_ctrl),
    .stall_fd  (stall_fd)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] r1,
                       input logic [RIDX_W-1:0] rs1, input logic [RIDX_W-1:0] rs2,
                       input logic [RIDX_W-1:0] rd, input ctrl_t c);
    id_valid  = v;
    id_pc     = pc;
    id_rdata1 = r1;
    id_rdata2 = 32'h0000_2222;
    id_imm    = 32'h0000_0004;
    id_rs1    = rs1;
    id_rs2    = rs2;
    id_rd     = rd;
    id_ctrl   = c;
    #1;
  endtask

  ctrl_t c_auipc, c_lw, c_add, c_lui, c_addi, c_sw;

  initial begin
    c_auipc = CTRL_NOP; c_auipc.is_AUIPC = 1'b1; c_auipc.reg_wr = 1'b1;
    c_lw    = CTRL_NOP; c_lw.mem_rd = 1'b1; c_lw.reg_wr = 1'b1; c_lw.wb_sel = WB_MEM;
    c_add   = CTRL_NOP; c_add.is_R_type = 1'b1; c_add.reg_wr = 1'b1;
    c_lui   = CTRL_NOP; c_lui.is_LUI = 1'b1; c_lui.reg_wr = 1'b1;
    c_addi  = CTRL_NOP; c_addi.reg_wr = 1'b1;
    c_sw    = CTRL_NOP; c_sw.mem_wr = 1'b1;

    rst_n    = 1'b0;
    ex_flush = 1'b0;
`ifdef ID_EX_RF_BYPASS_EN
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
`endif
    drive(1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, CTRL_NOP);
    tick();
    tick();
    check("rst_valid", 64'(ex_valid), 64'd0);
    check("rst_ctrl",  64'(ex_ctrl), 64'(CTRL_NOP));
    check("rst_stall", 64'(stall_fd), 64'd0);
    check("rst_pc",    64'(ex_pc), 64'd0);
    rst_n = 1'b1;

    // Pass-through of an AUIPC
    drive(1'b1, 32'h100, 32'hDEAD, 5'd0, 5'd0, 5'd7, c_auipc);
    tick();
    check("pt_pc",     64'(ex_pc), 64'h100);
    check("pt_rdata1", 64'(ex_rdata1), 64'hDEAD);
    check("pt_auipc",  64'(ex_ctrl.is_AUIPC), 64'd1);
    check("pt_valid",  64'(ex_valid), 64'd1);
    check("pt_rd",     64'(ex_rd), 64'd7);
    check("pt_stall",  64'(stall_fd), 64'd0);

    // lw x5 then add x6,x5,x1: one stall, one bubble, then capture
    drive(1'b1, 32'h104, 32'h0, 5'd2, 5'd0, 5'd5, c_lw);
    tick();
    drive(1'b1, 32'h108, 32'h0, 5'd5, 5'd1, 5'd6, c_add);
    check("lu_stall", 64'(stall_fd), 64'd1);
    tick();
    check("lu_bub_valid", 64'(ex_valid), 64'd0);
    check("lu_bub_ctrl",  64'(ex_ctrl), 64'(CTRL_NOP));
    check("lu_no_restall", 64'(stall_fd), 64'd0);
    tick();
    check("lu_cap_valid", 64'(ex_valid), 64'd1);
    check("lu_cap_rd",    64'(ex_rd), 64'd6);
    check("lu_cap_pc",    64'(ex_pc), 64'h108);
    check("lu_cap_stall", 64'(stall_fd), 64'd0);

    // lw x0 never stalls
    drive(1'b1, 32'h10C, 32'h0, 5'd2, 5'd0, 5'd0, c_lw);
    tick();
    drive(1'b1, 32'h110, 32'h0, 5'd0, 5'd0, 5'd6, c_add);
    check("x0_nostall", 64'(stall_fd), 64'd0);

    // lw x5; lui / I-type with matching unused fields do not stall; sw rs2=x5 does
    drive(1'b1, 32'h114, 32'h0, 5'd2, 5'd0, 5'd5, c_lw);
    tick();
    drive(1'b1, 32'h118, 32'h0, 5'd5, 5'd5, 5'd5, c_lui);
    check("lui_nostall", 64'(stall_fd), 64'd0);
    drive(1'b1, 32'h118, 32'h0, 5'd1, 5'd5, 5'd7, c_addi);
    check("itype_rs2_nostall", 64'(stall_fd), 64'd0);
    drive(1'b1, 32'h118, 32'h0, 5'd1, 5'd5, 5'd0, c_sw);
    check("sw_rs2_stall", 64'(stall_fd), 64'd1);

    // Flush over stall
    ex_flush = 1'b1;
    #1;
    check("fl_stall", 64'(stall_fd), 64'd0);
    tick();
    check("fl_valid", 64'(ex_valid), 64'd0);
    check("fl_ctrl",  64'(ex_ctrl), 64'(CTRL_NOP));
    ex_flush = 1'b0;

    // Flush with no hazard discards a normal instruction too
    drive(1'b1, 32'h200, 32'h0, 5'd1, 5'd2, 5'd3, c_add);
    ex_flush = 1'b1;
    tick();
    check("fl2_valid", 64'(ex_valid), 64'd0);
    check("fl2_regwr", 64'(ex_ctrl.reg_wr), 64'd0);
    ex_flush = 1'b0;

    // id_valid=0 captures a NOP control word but still latches data
    drive(1'b0, 32'h300, 32'h0, 5'd1, 5'd2, 5'd3, c_add);
    tick();
    check("inv_valid", 64'(ex_valid), 64'd0);
    check("inv_ctrl",  64'(ex_ctrl), 64'(CTRL_NOP));
    check("inv_pc",    64'(ex_pc), 64'h300);

    // Reset asserted mid-stall takes effect without a clock edge
    drive(1'b1, 32'h400, 32'h0, 5'd2, 5'd0, 5'd5, c_lw);
    tick();
    drive(1'b1, 32'h404, 32'h0, 5'd5, 5'd1, 5'd6, c_add);
    check("rs_pre_stall", 64'(stall_fd), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rs_valid", 64'(ex_valid), 64'd0);
    check("rs_ctrl",  64'(ex_ctrl), 64'(CTRL_NOP));
    check("rs_stall", 64'(stall_fd), 64'd0);
    check("rs_pc",    64'(ex_pc), 64'd0);
    check("rs_rd",    64'(ex_rd), 64'd0);
    tick();
    rst_n = 1'b1;

`ifdef ID_EX_RF_BYPASS_EN
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
    drive(1'b1, 32'h500, 32'h11, 5'd3, 5'd4, 5'd8, c_add);
    tick();
    check("byp_hit", 64'(ex_rdata1), 64'h55);
    check("byp_rs2_miss", 64'(ex_rdata2), 64'h2222);
    wb_rd = 5'd0;
    drive(1'b1, 32'h504, 32'h11, 5'd0, 5'd4, 5'd8, c_add);
    tick();
    check("byp_x0", 64'(ex_rdata1), 64'h11);
    wb_we = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
